sti_req_scheduler: RTL and testbench

- Sequences the parallel-to-serial STI datapath and shares it between two requesters, A and B.
- Uses round-robin arbitration across requesters.
- Latches one word per grant and drives the STI load and configuration inputs.
- Tracks serial completion through so_valid.
- When both requesters have sent their last word, issues the end pulse and waits for the memory-fill finish indication.

---
 rtl/sti_req_scheduler_if.sv | 73 +++++++
 rtl/sti_req_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_sti_req_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sti_req_scheduler_if.sv
// ---------------------------------------------------------------------------
// sti_req_scheduler_if
//   Bundles the two requester channels (A and B), the STI datapath control
//   and the status outputs of sti_req_scheduler.
//
//   Handshake (both requesters): a requester raises x_req together with
//   x_data / x_cfg / x_last and must hold all of them stable until it sees
//   x_gnt. x_gnt is a one-cycle pulse meaning "this word was accepted";
//   x_req may drop or present the next word in the same cycle as x_gnt.
//   There is no back-pressure on gnt.
//
//   Modports:
//     slave  - the scheduler side (takes requests, drives STI and status)
//     master - the environment side (requesters, STI block, observers)
//
//   Parameter: CNT_W - width of the per-requester issued-word counters.
// ---------------------------------------------------------------------------
interface sti_req_scheduler_if #(
  parameter int CNT_W = 8
) ();

  // Requester A
  logic             a_req;
  logic [15:0]      a_data;
  logic [4:0]       a_cfg;    // {length[1:0], fill, msb, low}
  logic             a_last;
  logic             a_gnt;

  // Requester B
  logic             b_req;
  logic [15:0]      b_data;
  logic [4:0]       b_cfg;
  logic             b_last;
  logic             b_gnt;

  // STI datapath control
  logic             sti_load;
  logic [15:0]      sti_data;
  logic [1:0]       sti_length;
  logic             sti_fill;
  logic             sti_msb;
  logic             sti_low;
  logic             sti_end;
  logic             sti_so_valid;
  logic             sti_oem_finish;

  // Status
  logic [CNT_W-1:0] a_cnt;
  logic [CNT_W-1:0] b_cnt;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       dbg_state;  // current FSM state, for observation only

  modport slave (
    input  a_req, a_data, a_cfg, a_last,
    input  b_req, b_data, b_cfg, b_last,
    input  sti_so_valid, sti_oem_finish,
    output a_gnt, b_gnt,
    output sti_load, sti_data, sti_length, sti_fill, sti_msb, sti_low, sti_end,
    output a_cnt, b_cnt, busy, done, err, dbg_state
  );

  modport master (
    output a_req, a_data, a_cfg, a_last,
    output b_req, b_data, b_cfg, b_last,
    output sti_so_valid, sti_oem_finish,
    input  a_gnt, b_gnt,
    input  sti_load, sti_data, sti_length, sti_fill, sti_msb, sti_low, sti_end,
    input  a_cnt, b_cnt, busy, done, err, dbg_state
  );

endinterface

// File: rtl/sti_req_scheduler.sv
// ---------------------------------------------------------------------------
// sti_req_scheduler
//   Shares one parallel-to-serial STI datapath between two requesters (A, B).
//   A round-robin arbiter grants one word at a time, the word and its
//   configuration are latched onto the STI inputs, a one-cycle load strobe is
//   issued and the scheduler then follows sti_so_valid until the serial
//   output of that word is complete. Once both requesters have delivered
//   their last word, an end pulse is sent and the scheduler waits for the
//   memory-fill finish indication before parking in DONE.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-low reset
//   bus    - sti_req_scheduler_if.slave: requester channels, STI control,
//            counters, busy/done/err and the FSM state (dbg_state)
//
// Parameters:
//   CNT_W    - width of the issued-word counters (wrap at 2^CNT_W)
//   WDOG_CYC - watchdog limit in cycles (exists only with STI_SCHED_WDOG_EN)
//
// Build option:
//   STI_SCHED_WDOG_EN - when defined, a watchdog bounds the time spent in
//   WAIT_V + SHIFT; on expiry err is set (sticky), the STI inputs are cleared
//   and the FSM returns to IDLE. When undefined, err is constant 0 and the
//   FSM waits on the STI indefinitely.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module sti_req_scheduler #(
  parameter int CNT_W    = 8
`ifdef STI_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYC = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  sti_req_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT_V = 3'd2,
    S_SHIFT  = 3'd3,
    S_END    = 3'd4,
    S_FLUSH  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;         // 0: A wins a contended grant, 1: B
  logic             a_fin_q, a_fin_d;
  logic             b_fin_q, b_fin_d;
  logic             a_gnt_q, a_gnt_d;
  logic             b_gnt_q, b_gnt_d;
  logic             sti_load_q, sti_load_d;
  logic             sti_end_q, sti_end_d;
  logic [15:0]      sti_data_q, sti_data_d;
  logic [4:0]       sti_cfg_q, sti_cfg_d; // {length[1:0], fill, msb, low}
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_elig, b_elig;
  logic             grant_a, grant_b;

`ifdef STI_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
`endif

  // A finished requester is never eligible again until reset.
  always_comb begin
    a_elig  = bus.a_req & ~a_fin_q;
    b_elig  = bus.b_req & ~b_fin_q;
    grant_a = (state_q == S_IDLE) & a_elig & (~b_elig | ~rr_q);
    grant_b = (state_q == S_IDLE) & b_elig & (~a_elig |  rr_q);
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    a_fin_d    = a_fin_q;
    b_fin_d    = b_fin_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    sti_load_d = 1'b0;
    sti_end_d  = 1'b0;
    sti_data_d = sti_data_q;
    sti_cfg_d  = sti_cfg_q;
    a_cnt_d    = a_cnt_q;
    b_cnt_d    = b_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (grant_a) begin
          sti_data_d = bus.a_data;
          sti_cfg_d  = bus.a_cfg;
          a_gnt_d    = 1'b1;
          a_cnt_d    = a_cnt_q + CNT_W'(1);
          a_fin_d    = bus.a_last;
          state_d    = S_ISSUE;
          // Pointer moves only when the grant was contended.
          if (b_elig) rr_d = 1'b1;
        end else if (grant_b) begin
          sti_data_d = bus.b_data;
          sti_cfg_d  = bus.b_cfg;
          b_gnt_d    = 1'b1;
          b_cnt_d    = b_cnt_q + CNT_W'(1);
          b_fin_d    = bus.b_last;
          state_d    = S_ISSUE;
          if (a_elig) rr_d = 1'b0;
        end else if (a_fin_q && b_fin_q) begin
          state_d = S_END;
        end
      end
      S_ISSUE: begin
        sti_load_d = 1'b1;
        state_d    = S_WAIT_V;
      end
      S_WAIT_V: begin
        if (bus.sti_so_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!bus.sti_so_valid) state_d = S_IDLE;
      end
      S_END: begin
        sti_end_d = 1'b1;
        state_d   = S_FLUSH;
      end
      S_FLUSH: begin
        if (bus.sti_oem_finish) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef STI_SCHED_WDOG_EN
    // Counts consecutive cycles spent in the same waiting state; any state
    // change (including WAIT_V -> SHIFT) restarts it.
    wdog_d = '0;
    err_d  = err_q;
    if ((state_q == S_WAIT_V || state_q == S_SHIFT) && state_d == state_q) begin
      if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
        err_d      = 1'b1;
        state_d    = S_IDLE;
        sti_load_d = 1'b0;
        sti_data_d = '0;
        sti_cfg_d  = '0;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
`endif

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      a_fin_q    <= 1'b0;
      b_fin_q    <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      sti_load_q <= 1'b0;
      sti_end_q  <= 1'b0;
      sti_data_q <= '0;
      sti_cfg_q  <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STI_SCHED_WDOG_EN
      wdog_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      a_fin_q    <= a_fin_d;
      b_fin_q    <= b_fin_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      sti_load_q <= sti_load_d;
      sti_end_q  <= sti_end_d;
      sti_data_q <= sti_data_d;
      sti_cfg_q  <= sti_cfg_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef STI_SCHED_WDOG_EN
      wdog_q     <= wdog_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.a_gnt      = a_gnt_q;
  assign bus.b_gnt      = b_gnt_q;
  assign bus.sti_load   = sti_load_q;
  assign bus.sti_data   = sti_data_q;
  assign bus.sti_length = sti_cfg_q[4:3];
  assign bus.sti_fill   = sti_cfg_q[2];
  assign bus.sti_msb    = sti_cfg_q[1];
  assign bus.sti_low    = sti_cfg_q[0];
  assign bus.sti_end    = sti_end_q;
  assign bus.a_cnt      = a_cnt_q;
  assign bus.b_cnt      = b_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;
`ifdef STI_SCHED_WDOG_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_sti_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sti_req_scheduler
//   Directed sequence with randomized words. A behavioural STI model answers
//   each load with 8*(length+1) so_valid cycles; a scoreboard queue holds the
//   words the arbitration model says must reach the STI, in order.
// ---------------------------------------------------------------------------
module tb_sti_req_scheduler;

  localparam int CNT_W = 8;
`ifdef STI_SCHED_WDOG_EN
  localparam int MAX_LEN = 0;   // keep normal traffic inside the 16-cycle watchdog
`else
  localparam int MAX_LEN = 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sti_req_scheduler_if #(.CNT_W(CNT_W)) bus ();

`ifdef STI_SCHED_WDOG_EN
  sti_req_scheduler #(.CNT_W(CNT_W), .WDOG_CYC(16)) dut (.clk(clk), .reset(rst_n), .bus(bus));
`else
  sti_req_scheduler #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(rst_n), .bus(bus));
`endif

  // ---------------- bookkeeping ----------------
  int   checks = 0;
  int   errors = 0;
  logic [20:0] exp_q[$];        // {length, fill, msb, low, data}
  bit   sti_mute   = 1'b0;
  bit   sti_active = 1'b0;
  bit   fix_en     = 1'b0;
  logic [20:0] fix_word;
  time  gnt_time;

  // reference model state
  bit          m_rr;            // 0: A wins contention
  bit          m_a_fin, m_b_fin;
  logic [CNT_W-1:0] m_a_cnt, m_b_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] cur_word();
    return {bus.sti_length, bus.sti_fill, bus.sti_msb, bus.sti_low, bus.sti_data};
  endfunction

  function automatic logic [43:0] out_vec();
    return {bus.a_gnt, bus.b_gnt, bus.sti_load, bus.sti_data, bus.sti_length,
            bus.sti_fill, bus.sti_msb, bus.sti_low, bus.sti_end,
            bus.a_cnt, bus.b_cnt, bus.busy, bus.done, bus.err};
  endfunction

  function automatic logic [20:0] new_word();
    logic [20:0] w;
    if (fix_en) return fix_word;
    w[15:0]  = 16'($urandom);
    w[18:16] = 3'($urandom_range(0, 7));
    w[20:19] = 2'($urandom_range(0, MAX_LEN));
    return w;
  endfunction

  // Round-robin rule: a lone eligible requester wins; on contention the
  // pointer side wins and the pointer moves to the other side.
  function automatic int model_pick(input bit ea, input bit eb);
    int w;
    if (ea && eb) begin
      w    = m_rr ? 2 : 1;
      m_rr = ~m_rr;
      return w;
    end
    if (ea) return 1;
    if (eb) return 2;
    return 0;
  endfunction

  // ---------------- STI behavioural model + scoreboard ----------------
  initial begin : sti_model
    logic [20:0] w;
    int          n;
    bit          hold_ok, aborted;
    bus.sti_so_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        bus.sti_so_valid = 1'b0;
        sti_active       = 1'b0;
      end else if (bus.sti_load === 1'b1) begin
        sti_active = 1'b1;
        check("sb_nonempty", exp_q.size() != 0, 1);
        w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("sb_word", cur_word(), w);
        if (!sti_mute) begin
          n = 8 * (int'(w[20:19]) + 1);
          @(negedge clk);                 // STI set-up cycle
          hold_ok = 1'b1;
          aborted = 1'b0;
          for (int i = 0; i < n; i++) begin
            bus.sti_so_valid = 1'b1;
            @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (cur_word() !== w) hold_ok = 1'b0;
          end
          bus.sti_so_valid = 1'b0;
          if (!aborted) check("sti_hold", hold_ok, 1);
        end
        sti_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input bit r, input logic [20:0] w, input bit l);
    bus.a_req = r; bus.a_cfg = w[20:16]; bus.a_data = w[15:0]; bus.a_last = l;
  endtask

  task automatic drive_b(input bit r, input logic [20:0] w, input bit l);
    bus.b_req = r; bus.b_cfg = w[20:16]; bus.b_data = w[15:0]; bus.b_last = l;
  endtask

  task automatic model_reset();
    m_rr = 1'b0; m_a_fin = 1'b0; m_b_fin = 1'b0; m_a_cnt = '0; m_b_cnt = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_a(1'b0, '0, 1'b0);
    drive_b(1'b0, '0, 1'b0);
    bus.sti_oem_finish = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy !== 1'b0 && n < 500);
    check("wait_idle_timeout", bus.busy, 0);
  endtask

  // Requester A offers na words and B offers nb words, each holding req high
  // back-to-back; the final word of a side carries its last flag if asked.
  task automatic run(input int na, input int nb, input bit a_l, input bit b_l);
    int ra, rb, budget, pick;
    logic [20:0] wa, wb;
    ra = na; rb = nb; wa = '0; wb = '0;
    @(negedge clk);
    if (ra > 0) begin wa = new_word(); drive_a(1'b1, wa, a_l && ra == 1); end
    if (rb > 0) begin wb = new_word(); drive_b(1'b1, wb, b_l && rb == 1); end
    budget = 0;
    while ((ra > 0 || rb > 0) && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (bus.a_gnt === 1'b1 || bus.b_gnt === 1'b1) begin
        pick = model_pick(ra > 0 && !m_a_fin, rb > 0 && !m_b_fin);
        check("gnt_side", {bus.a_gnt, bus.b_gnt},
              (pick == 1) ? 2'b10 : (pick == 2) ? 2'b01 : 2'b00);
        check("gnt_while_sti_busy", sti_active, 0);
        gnt_time = $time;
        if (pick == 1) begin
          m_a_cnt++; m_a_fin = a_l && ra == 1; exp_q.push_back(wa); ra--;
          if (ra > 0) begin wa = new_word(); drive_a(1'b1, wa, a_l && ra == 1); end
          else drive_a(1'b0, '0, 1'b0);
        end else if (pick == 2) begin
          m_b_cnt++; m_b_fin = b_l && rb == 1; exp_q.push_back(wb); rb--;
          if (rb > 0) begin wb = new_word(); drive_b(1'b1, wb, b_l && rb == 1); end
          else drive_b(1'b0, '0, 1'b0);
        end
        check("a_cnt", bus.a_cnt, m_a_cnt);
        check("b_cnt", bus.b_cnt, m_b_cnt);
        @(negedge clk);
        budget++;
        check("load_after_gnt", {bus.sti_load, bus.a_gnt, bus.b_gnt}, 3'b100);
      end
    end
    check("run_words_left", ra + rb, 0);
    drive_a(1'b0, '0, 1'b0);
    drive_b(1'b0, '0, 1'b0);
    wait_idle();
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [20:0] w;
    int          n;
    bit          bad;

    rst_n = 1'b0;
    drive_a(1'b0, '0, 1'b0);
    drive_b(1'b0, '0, 1'b0);
    bus.sti_oem_finish = 1'b0;
    do_reset();
    @(negedge clk);
    check("reset_outputs", out_vec(), 0);

    // Single A word: data 00A5, length 0, msb 1, low 0, fill 0.
    fix_en   = 1'b1;
    fix_word = {2'b00, 1'b0, 1'b1, 1'b0, 16'h00A5};
    run(1, 0, 1'b0, 1'b0);
    fix_en   = 1'b0;
    check("single_a_cnt", bus.a_cnt, 1);

    // Both requesting continuously: alternation from the model.
    run(4, 4, 1'b0, 1'b0);
    run(3, 2, 1'b0, 1'b0);

    // A delivers its last word.
    run(2, 0, 1'b1, 1'b0);

    // Finished A keeps requesting: never granted, scheduler stays idle.
    @(negedge clk);
    drive_a(1'b1, new_word(), 1'b0);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.a_gnt !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    check("fin_req_ignored", bad, 0);
    drive_a(1'b0, '0, 1'b0);

    // B's last word completes the job: END pulse, FLUSH, DONE.
    run(0, 1, 1'b0, 1'b1);
    n = 0;
    while (bus.sti_end !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("end_seen", bus.sti_end, 1);
    @(negedge clk);
    check("end_pulse_flush", {bus.sti_end, bus.busy, bus.done}, 3'b010);
    repeat (5) @(negedge clk);
    check("flush_waits", {bus.busy, bus.done}, 2'b10);
    bus.sti_oem_finish = 1'b1;
    @(negedge clk);
    bus.sti_oem_finish = 1'b0;
    check("done_state", {bus.busy, bus.done}, 2'b01);
    drive_a(1'b1, new_word(), 1'b0);
    drive_b(1'b1, new_word(), 1'b0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0 || bus.done !== 1'b1) bad = 1'b1;
    end
    check("done_blocks_grants", bad, 0);
    check("cnt_kept", {bus.a_cnt, bus.b_cnt}, {m_a_cnt, m_b_cnt});

    // Reset in the middle of a 32-bit word.
    do_reset();
    w = new_word();
    w[20:19] = 2'b11;
    @(negedge clk);
    drive_a(1'b1, w, 1'b0);
    n = 0;
    while (bus.a_gnt !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_gnt_seen", bus.a_gnt, 1);
    m_a_cnt++;
    exp_q.push_back(w);
    drive_a(1'b0, '0, 1'b0);
    n = 0;
    while (bus.sti_so_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_valid_seen", bus.sti_so_valid, 1);
    repeat (6) @(negedge clk);
    check("mid_in_shift", {bus.busy, bus.a_cnt}, {1'b1, m_a_cnt});
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_shift", out_vec(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Pointer is back on A: first contended grant goes to A.
    run(1, 1, 1'b0, 1'b0);
    check("err_low", bus.err, 0);

`ifdef STI_SCHED_WDOG_EN
    sti_mute = 1'b1;
    run(1, 0, 1'b0, 1'b0);
    check("wdog_err", bus.err, 1);
    check("wdog_latency", $time - gnt_time, 170);
    check("wdog_sti_cleared", {bus.sti_load, cur_word()}, 0);
    sti_mute = 1'b0;
    run(1, 0, 1'b0, 1'b0);
    check("wdog_err_sticky", bus.err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
